// File: rtl/mem_arbiter.sv
// Word-level arbiter between the icache/dcache memory ports and a single RAM port.
// The dcache wins by default; the icache is forced in after D_MAX back-to-back dcache words.
module mem_arbiter #(
  parameter int          D_MAX    = 4,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  input  logic        ram_error,
  output logic        err_flag
);

  typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

  localparam logic [2:0] DCNT_MAX = 3'(D_MAX);

  state_t      state_q, state_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic        err_q, err_d;
  logic        d_req;
  logic        ram_done;
  logic [31:0] word_in;

  assign d_req    = dREN | dWEN;
  assign ram_done = ram_ready | ram_error;
  // An error completion wins over a simultaneous ready.
  assign word_in  = ram_error ? ERR_WORD : ramload;
  assign err_flag = err_q;

  function automatic state_t arb(input logic dq, input logic iq, input logic [2:0] cnt);
    if (dq && !(iq && cnt == DCNT_MAX))
      return DSERV;
    else if (iq)
      return ISERV;
    else
      return IDLE;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      dcnt_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    err_d    = err_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'd0;
    dload    = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;

    case (state_q)
      IDLE: begin
        state_d = arb(d_req, iREN, dcnt_q);
      end

      DSERV: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (dWEN) ramWEN = 1'b1;
          else      ramREN = 1'b1;
          if (ram_done) begin
            dwait = 1'b0;
            dload = word_in;
            if (ram_error) err_d = 1'b1;
            if (!iREN)                    dcnt_d = 3'd0;
            else if (dcnt_q != DCNT_MAX) dcnt_d = dcnt_q + 3'd1;
            // Re-arbitrate with the updated count so the next word issues without a bubble.
            state_d = arb(d_req, iREN, dcnt_d);
          end
        end
      end

      ISERV: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            iwait  = 1'b0;
            iload  = word_in;
            dcnt_d = 3'd0;
            if (ram_error) err_d = 1'b1;
            state_d = arb(d_req, iREN, dcnt_d);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
